// File: rtl/rename_ckpt_stage_pkg.sv
// Shared types and sizing for the checkpointed rename stage.
// Sizes are fixed here (16 arch regs, 64 phys regs, 4 checkpoints) so every file agrees on widths.
package rename_ckpt_stage_pkg;

  localparam int unsigned NumArchReg = 16;
  localparam int unsigned NumPhysReg = 64;
  localparam int unsigned NumCkpt    = 4;
  localparam int unsigned Aw         = $clog2(NumArchReg);
  localparam int unsigned Pw         = $clog2(NumPhysReg);
  localparam int unsigned Cw         = $clog2(NumCkpt);

  typedef logic [Aw-1:0] arch_reg_t;
  typedef logic [Pw-1:0] phys_reg_t;
  typedef logic [Cw-1:0] ckpt_id_t;
  // One extra bit so full and empty are distinguishable.
  typedef logic [Pw:0]   fl_ptr_t;
  typedef logic [Cw:0]   ckpt_ptr_t;
  typedef phys_reg_t [NumArchReg-1:0] map_t;

  typedef struct packed {
    arch_reg_t src1;
    arch_reg_t src2;
    arch_reg_t dest;
    logic      w_v;
    logic      branch;
  } rename_req_t;

  typedef struct packed {
    phys_reg_t src1;
    phys_reg_t src2;
    phys_reg_t dest;
    phys_reg_t freed;
    ckpt_id_t  ckpt_id;
  } rename_rsp_t;

  typedef struct packed {
    map_t    lut;
    fl_ptr_t rd_ptr;
  } ckpt_entry_t;

  function automatic map_t identity_map();
    map_t m;
    for (int i = 0; i < NumArchReg; i++) m[i] = phys_reg_t'(i);
    return m;
  endfunction

endpackage

// File: rtl/rename_freelist.sv
// Circular free list of physical registers.
// Ports: alloc_i pops the head, load_i overwrites the read pointer (recovery, wins over alloc_i),
// push_i appends a register returned at commit. head_o is the next register to hand out,
// rd_ptr_o the current read pointer and free_cnt_o the number of free entries.
module rename_freelist
  import rename_ckpt_stage_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      alloc_i,
  input  logic      load_i,
  input  fl_ptr_t   load_ptr_i,
  input  logic      push_i,
  input  phys_reg_t push_data_i,
  output phys_reg_t head_o,
  output fl_ptr_t   rd_ptr_o,
  output fl_ptr_t   free_cnt_o
);

  phys_reg_t fl_q [NumPhysReg];
  fl_ptr_t   rd_ptr_q, rd_ptr_d, wr_ptr_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (load_i) begin
      rd_ptr_d = load_ptr_i;
    end else if (alloc_i) begin
      rd_ptr_d = rd_ptr_q + fl_ptr_t'(1);
    end
  end

  // Entries past NumPhysReg-NumArchReg hold don't-care values; they are written before being read.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < NumPhysReg; k++) fl_q[k] <= phys_reg_t'(NumArchReg + k);
      rd_ptr_q <= '0;
      wr_ptr_q <= fl_ptr_t'(NumPhysReg - NumArchReg);
    end else begin
      rd_ptr_q <= rd_ptr_d;
      if (push_i) begin
        fl_q[wr_ptr_q[Pw-1:0]] <= push_data_i;
        wr_ptr_q               <= wr_ptr_q + fl_ptr_t'(1);
      end
    end
  end

  assign head_o     = fl_q[rd_ptr_q[Pw-1:0]];
  assign rd_ptr_o   = rd_ptr_q;
  assign free_cnt_o = wr_ptr_q - rd_ptr_q;

  // Only registers that were allocated are ever returned, so the list cannot overfill.
  assert property (@(posedge clk_i) disable iff (reset_i)
                   free_cnt_o <= fl_ptr_t'(NumPhysReg - NumArchReg));

endmodule

// File: rtl/rename_ckpt_stage.sv
// Single-issue rename stage with per-branch checkpoints.
// Ports: dec_* (decoded instruction in, dec_ready_o back-pressure), ren_* (registered renamed
// instruction with valid/ready), commit_* (in-order retirement updating committed state),
// resolve_* (branch resolution, any order) and flush_i (restore committed state).
// Build option RENAME_ZERO_REG_EN: arch reg 0 is hardwired to phys 0 and never renamed.
module rename_ckpt_stage
  import rename_ckpt_stage_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          dec_v_i,
  output logic          dec_ready_o,
  input  logic [Aw-1:0] dec_src1_i,
  input  logic [Aw-1:0] dec_src2_i,
  input  logic [Aw-1:0] dec_dest_i,
  input  logic          dec_w_v_i,
  input  logic          dec_branch_i,
  output logic          ren_v_o,
  input  logic          ren_ready_i,
  output logic [Pw-1:0] ren_src1_o,
  output logic [Pw-1:0] ren_src2_o,
  output logic [Pw-1:0] ren_dest_o,
  output logic [Pw-1:0] ren_freed_o,
  output logic [Cw-1:0] ren_ckpt_id_o,
  input  logic          commit_v_i,
  input  logic          commit_w_v_i,
  input  logic [Aw-1:0] commit_dest_arch_i,
  input  logic [Pw-1:0] commit_dest_phys_i,
  input  logic [Pw-1:0] commit_freed_i,
  input  logic          resolve_v_i,
  input  logic          resolve_mispred_i,
  input  logic [Cw-1:0] resolve_ckpt_id_i,
  input  logic          flush_i
);

  map_t        spec_lut_q, spec_lut_d, cm_lut_q, cm_lut_d;
  fl_ptr_t     cm_rd_ptr_q, cm_rd_ptr_d;
  ckpt_entry_t ckpt_q [NumCkpt];
  logic [NumCkpt-1:0] done_q, done_d;
  ckpt_ptr_t   head_q, head_d, tail_q, tail_d, ckpt_cnt;
  ckpt_id_t    head_idx, tail_idx;
  logic        ren_v_q, ren_v_d;
  rename_rsp_t ren_q, ren_d;
  rename_req_t req;

  logic        mispred, accept, alloc, commit_w, fl_load, dest_zero, commit_zero;
  fl_ptr_t     fl_rd_ptr, free_cnt, fl_load_ptr;
  phys_reg_t   fl_head;

  assign req = '{src1: dec_src1_i, src2: dec_src2_i, dest: dec_dest_i,
                 w_v: dec_w_v_i, branch: dec_branch_i};

`ifdef RENAME_ZERO_REG_EN
  assign dest_zero   = (req.dest == '0);
  assign commit_zero = (commit_dest_arch_i == '0);
`else
  assign dest_zero   = 1'b0;
  assign commit_zero = 1'b0;
`endif

  assign mispred  = resolve_v_i & resolve_mispred_i;
  assign head_idx = head_q[Cw-1:0];
  assign tail_idx = tail_q[Cw-1:0];
  assign ckpt_cnt = tail_q - head_q;

  // Deliberately independent of w_v/branch so ready never waits on decode fields.
  assign dec_ready_o = (!ren_v_q | ren_ready_i) & (free_cnt != '0) &
                       (ckpt_cnt != ckpt_ptr_t'(NumCkpt)) & !flush_i & !mispred;
  assign accept   = dec_v_i & dec_ready_o;
  assign alloc    = accept & req.w_v & !dest_zero;
  assign commit_w = commit_v_i & commit_w_v_i & !commit_zero;

  rename_freelist u_freelist (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .alloc_i     (alloc),
    .load_i      (fl_load),
    .load_ptr_i  (fl_load_ptr),
    .push_i      (commit_w),
    .push_data_i (commit_freed_i),
    .head_o      (fl_head),
    .rd_ptr_o    (fl_rd_ptr),
    .free_cnt_o  (free_cnt)
  );

  always_comb begin
    cm_lut_d    = cm_lut_q;
    cm_rd_ptr_d = cm_rd_ptr_q;
    if (commit_w) begin
      cm_lut_d[commit_dest_arch_i] = commit_dest_phys_i;
      cm_rd_ptr_d                  = cm_rd_ptr_q + fl_ptr_t'(1);
    end
  end

  // Flush restores the committed state including this cycle's commit.
  always_comb begin
    spec_lut_d  = spec_lut_q;
    fl_load     = 1'b0;
    fl_load_ptr = cm_rd_ptr_d;
    if (flush_i) begin
      spec_lut_d = cm_lut_d;
      fl_load    = 1'b1;
    end else if (mispred) begin
      spec_lut_d  = ckpt_q[resolve_ckpt_id_i].lut;
      fl_load     = 1'b1;
      fl_load_ptr = ckpt_q[resolve_ckpt_id_i].rd_ptr;
    end else if (alloc) begin
      spec_lut_d[req.dest] = fl_head;
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    done_d = done_q;
    if ((ckpt_cnt != '0) && done_q[head_idx]) begin
      head_d           = head_q + ckpt_ptr_t'(1);
      done_d[head_idx] = 1'b0;
    end
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      done_d = '0;
    end else if (mispred) begin
      // Keep the mispredicted checkpoint, drop all younger ones; it is resolved, so mark it done
      // and let the head retire it.
      tail_d = head_q + ckpt_ptr_t'(ckpt_id_t'(resolve_ckpt_id_i - head_idx)) + ckpt_ptr_t'(1);
      done_d[resolve_ckpt_id_i] = 1'b1;
    end else begin
      if (resolve_v_i) done_d[resolve_ckpt_id_i] = 1'b1;
      if (accept & req.branch) begin
        done_d[tail_idx] = 1'b0;
        tail_d           = tail_q + ckpt_ptr_t'(1);
      end
    end
  end

  always_comb begin
    ren_v_d = ren_v_q;
    ren_d   = ren_q;
    if (flush_i | mispred) begin
      ren_v_d = 1'b0;
    end else if (accept) begin
      ren_v_d       = 1'b1;
      ren_d.src1    = spec_lut_q[req.src1];
      ren_d.src2    = spec_lut_q[req.src2];
      ren_d.dest    = alloc ? fl_head : '0;
      ren_d.freed   = alloc ? spec_lut_q[req.dest] : '0;
      ren_d.ckpt_id = req.branch ? tail_idx : '0;
    end else if (ren_ready_i) begin
      ren_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      spec_lut_q  <= identity_map();
      cm_lut_q    <= identity_map();
      cm_rd_ptr_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      done_q      <= '0;
      ren_v_q     <= 1'b0;
      ren_q       <= '0;
    end else begin
      spec_lut_q  <= spec_lut_d;
      cm_lut_q    <= cm_lut_d;
      cm_rd_ptr_q <= cm_rd_ptr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      done_q      <= done_d;
      ren_v_q     <= ren_v_d;
      ren_q       <= ren_d;
    end
  end

  // Snapshot is the post-rename state, so a branch that writes a register keeps its own mapping.
  always_ff @(posedge clk_i) begin
    if (accept & req.branch) begin
      ckpt_q[tail_idx] <= '{lut: spec_lut_d, rd_ptr: fl_rd_ptr + fl_ptr_t'(alloc)};
    end
  end

  assign ren_v_o       = ren_v_q;
  assign ren_src1_o    = ren_q.src1;
  assign ren_src2_o    = ren_q.src2;
  assign ren_dest_o    = ren_q.dest;
  assign ren_freed_o   = ren_q.freed;
  assign ren_ckpt_id_o = ren_q.ckpt_id;

endmodule

// File: tb/tb_rename_ckpt_stage.sv
// Randomized bench for rename_ckpt_stage with a reference model built from plain arrays/queues.
module tb_rename_ckpt_stage;

  localparam int NA = 16;
  localparam int NC = 4;
`ifdef RENAME_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       dec_v_i, dec_ready_o, dec_w_v_i, dec_branch_i;
  logic [3:0] dec_src1_i, dec_src2_i, dec_dest_i;
  logic       ren_v_o, ren_ready_i;
  logic [5:0] ren_src1_o, ren_src2_o, ren_dest_o, ren_freed_o;
  logic [1:0] ren_ckpt_id_o;
  logic       commit_v_i, commit_w_v_i;
  logic [3:0] commit_dest_arch_i;
  logic [5:0] commit_dest_phys_i, commit_freed_i;
  logic       resolve_v_i, resolve_mispred_i;
  logic [1:0] resolve_ckpt_id_i;
  logic       flush_i;

  always #5 clk_i = ~clk_i;

  rename_ckpt_stage dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .dec_v_i            (dec_v_i),
    .dec_ready_o        (dec_ready_o),
    .dec_src1_i         (dec_src1_i),
    .dec_src2_i         (dec_src2_i),
    .dec_dest_i         (dec_dest_i),
    .dec_w_v_i          (dec_w_v_i),
    .dec_branch_i       (dec_branch_i),
    .ren_v_o            (ren_v_o),
    .ren_ready_i        (ren_ready_i),
    .ren_src1_o         (ren_src1_o),
    .ren_src2_o         (ren_src2_o),
    .ren_dest_o         (ren_dest_o),
    .ren_freed_o        (ren_freed_o),
    .ren_ckpt_id_o      (ren_ckpt_id_o),
    .commit_v_i         (commit_v_i),
    .commit_w_v_i       (commit_w_v_i),
    .commit_dest_arch_i (commit_dest_arch_i),
    .commit_dest_phys_i (commit_dest_phys_i),
    .commit_freed_i     (commit_freed_i),
    .resolve_v_i        (resolve_v_i),
    .resolve_mispred_i  (resolve_mispred_i),
    .resolve_ckpt_id_i  (resolve_ckpt_id_i),
    .flush_i            (flush_i)
  );

  typedef logic [NA-1:0][5:0] tmap_t;
  typedef struct packed {int id; int seq; logic done; tmap_t lut; int rd;} ck_t;
  typedef struct packed {
    int seq; logic br; logic res; logic w_v;
    logic [3:0] arch; logic [5:0] phys; logic [5:0] freed;
  } rob_t;

  int checks = 0;
  int failures = 0;
  logic [25:0] sb[$];  // {src1, src2, dest, freed, ckpt_id}

  // Reference model state.
  tmap_t      lut, cm_lut;
  logic [5:0] fl_hist[$];  // every register ever put on the free list, in order
  int         rd, cm_rd, tail_id, seq_ctr, held_seq;
  bit         ov;
  ck_t        ck[$];
  rob_t       rob[$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  // Monitor: one expected response per issue handshake.
  initial begin
    logic [25:0] got, e;
    forever begin
      @(negedge clk_i);
      if (!reset_i && ren_v_o && ren_ready_i) begin
        got = {ren_src1_o, ren_src2_o, ren_dest_o, ren_freed_o, ren_ckpt_id_o};
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected got=%0h exp=none t=%0t", got, $time);
        end else begin
          e = sb.pop_front();
          check("rsp", 32'(got), 32'(e));
        end
      end
    end
  end

  // Phase knobs (percent): dec_v, ren_ready, branch, resolve, mispredict, commit, flush
  int ph [0:6][0:6] = '{
    '{90, 90, 10, 20, 30, 60, 1},
    '{100, 100, 5, 10, 0, 0, 0},
    '{90, 50, 5, 30, 20, 90, 0},
    '{90, 90, 60, 3, 0, 30, 0},
    '{90, 90, 40, 40, 50, 50, 2},
    '{80, 70, 20, 20, 30, 50, 5},
    '{0, 100, 0, 0, 0, 0, 0}
  };

  initial begin
    bit          dv, rr, fl, wv, br, rv, rm, cv, mready, acc, al, rel;
    logic [3:0]  s1, s2, dst;
    logic [25:0] ex;
    rob_t        cf;
    int          rseq, k0, kk, ncyc;
    int          cand[$];

    reset_i = 1'b1;
    dec_v_i = 1'b0; dec_src1_i = '0; dec_src2_i = '0; dec_dest_i = '0;
    dec_w_v_i = 1'b0; dec_branch_i = 1'b0; ren_ready_i = 1'b0;
    commit_v_i = 1'b0; commit_w_v_i = 1'b0; commit_dest_arch_i = '0;
    commit_dest_phys_i = '0; commit_freed_i = '0;
    resolve_v_i = 1'b0; resolve_mispred_i = 1'b0; resolve_ckpt_id_i = '0; flush_i = 1'b0;

    for (int i = 0; i < NA; i++) begin
      lut[i] = 6'(i);
      cm_lut[i] = 6'(i);
    end
    for (int i = 0; i < 48; i++) fl_hist.push_back(6'(NA + i));
    rd = 0; cm_rd = 0; tail_id = 0; seq_ctr = 0; held_seq = -1; ov = 1'b0;

    repeat (2) @(posedge clk_i);
    #1;
    check("reset_ren_v", 32'(ren_v_o), 32'd0);
    check("reset_ren_data", 32'({ren_src1_o, ren_src2_o, ren_dest_o, ren_freed_o, ren_ckpt_id_o}),
          32'd0);
    reset_i = 1'b0;
    #1;
    check("reset_ready", 32'(dec_ready_o), 32'd1);

    for (int p = 0; p < 7; p++) begin
      ncyc = (p == 6) ? 10 : 400;
      for (int c = 0; c < ncyc; c++) begin
        @(posedge clk_i);
        #1;
        dv  = pct(ph[p][0]);
        rr  = pct(ph[p][1]);
        fl  = pct(ph[p][6]);
        s1  = 4'($urandom_range(0, 15));
        s2  = 4'($urandom_range(0, 15));
        dst = 4'($urandom_range(0, 15));
        wv  = pct(80);
        br  = pct(ph[p][2]);
        rv = 1'b0; rm = 1'b0; rseq = -1;
        resolve_ckpt_id_i = 2'($urandom_range(0, 3));
        if (!fl && pct(ph[p][3])) begin
          cand.delete();
          foreach (ck[k]) if (!ck[k].done && !(ov && ck[k].seq == held_seq)) cand.push_back(k);
          if (cand.size() > 0) begin
            k0 = cand[$urandom_range(0, unsigned'(cand.size() - 1))];
            rv = 1'b1;
            rm = pct(ph[p][4]);
            resolve_ckpt_id_i = 2'(ck[k0].id);
            rseq = ck[k0].seq;
          end
        end
        cv = 1'b0;
        cf = '0;
        if (rob.size() > 0 && pct(ph[p][5]) && (!rob[0].br || rob[0].res)) begin
          cv = 1'b1;
          cf = rob[0];
        end
        dec_v_i = dv; dec_src1_i = s1; dec_src2_i = s2; dec_dest_i = dst;
        dec_w_v_i = wv; dec_branch_i = br; ren_ready_i = rr; flush_i = fl;
        resolve_v_i = rv; resolve_mispred_i = rm;
        commit_v_i = cv;
        commit_w_v_i       = cv ? cf.w_v : 1'($urandom_range(0, 1));
        commit_dest_arch_i = cv ? cf.arch : 4'($urandom_range(0, 15));
        commit_dest_phys_i = cv ? cf.phys : 6'($urandom_range(0, 63));
        commit_freed_i     = cv ? cf.freed : 6'($urandom_range(0, 63));
        #1;

        mready = (!ov || rr) && (fl_hist.size() - rd != 0) && (ck.size() != NC) && !fl &&
                 !(rv && rm);
        check("dec_ready", 32'(dec_ready_o), 32'(mready));
        check("ren_v", 32'(ren_v_o), 32'(ov));
        acc = dv && mready;
        al  = acc && wv && !(ZeroReg && dst == 4'd0);
        ex  = '0;
        if (acc) ex = {lut[s1], lut[s2], al ? fl_hist[rd] : 6'd0, al ? lut[dst] : 6'd0,
                       br ? 2'(tail_id) : 2'd0};

        // Retirement returns the old mapping and advances committed state.
        if (cv) begin
          if (cf.w_v && !(ZeroReg && cf.arch == 4'd0)) begin
            fl_hist.push_back(cf.freed);
            cm_rd++;
            cm_lut[cf.arch] = cf.phys;
          end
          void'(rob.pop_front());
        end
        // Oldest checkpoint leaves once it was already resolved before this cycle.
        rel = (ck.size() > 0) && ck[0].done;
        if (rel) void'(ck.pop_front());

        if (fl || (rv && rm)) begin
          if (ov && !rr) void'(sb.pop_back());
          ov = 1'b0;
        end else if (acc) begin
          sb.push_back(ex);
          ov = 1'b1;
          held_seq = seq_ctr;
        end else if (rr) begin
          ov = 1'b0;
        end

        if (fl) begin
          lut = cm_lut;
          rd = cm_rd;
          ck.delete();
          rob.delete();
          tail_id = 0;
        end else if (rv && rm) begin
          kk = -1;
          foreach (ck[k]) if (ck[k].seq == rseq) kk = k;
          lut = ck[kk].lut;
          rd = ck[kk].rd;
          ck[kk].done = 1'b1;
          tail_id = (ck[kk].id + 1) % NC;
          while (ck.size() > kk + 1) void'(ck.pop_back());
          while (rob.size() > 0 && rob[$].seq > rseq) void'(rob.pop_back());
          foreach (rob[j]) if (rob[j].seq == rseq) rob[j].res = 1'b1;
        end else begin
          if (rv) begin
            foreach (ck[k]) if (ck[k].seq == rseq) ck[k].done = 1'b1;
            foreach (rob[j]) if (rob[j].seq == rseq) rob[j].res = 1'b1;
          end
          if (acc) begin
            if (al) begin
              lut[dst] = fl_hist[rd];
              rd++;
            end
            rob.push_back('{seq: seq_ctr, br: br, res: 1'b0, w_v: wv, arch: dst,
                            phys: ex[13:8], freed: ex[7:2]});
            if (br) begin
              ck.push_back('{id: tail_id, seq: seq_ctr, done: 1'b0, lut: lut, rd: rd});
              tail_id = (tail_id + 1) % NC;
            end
            seq_ctr++;
          end
        end
      end
    end

    @(posedge clk_i);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
